// File: rtl/sort_pkg.sv
// rtl/sort_pkg.sv - shared defaults and FSM state encoding for the sort RAM arbiter
package sort_pkg;

  localparam int unsigned SORT_AW = 4;
  localparam int unsigned SORT_DW = 8;

  typedef logic [1:0] state_t;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_HOST   = 2'd1;
  localparam logic [1:0] ST_LAUNCH = 2'd2;
  localparam logic [1:0] ST_RUN    = 2'd3;

endpackage

// File: rtl/sort_wdog_cnt.sv
// rtl/sort_wdog_cnt.sv - RUN-phase watchdog counter, flags the cycle on which the count reaches 2**W-1
module sort_wdog_cnt #(
  parameter int unsigned W = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clr_i,
  input  logic inc_i,
  output logic expire_o
);

  // Last counting cycle: the value held is 2**W-2, so this increment would reach the limit.
  localparam logic [W-1:0] LAST = {{(W-1){1'b1}}, 1'b0};

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expire_o = inc_i && (cnt_q == LAST);

endmodule

// File: rtl/sort_mem_arbiter.sv
// rtl/sort_mem_arbiter.sv - shares the single-port sort RAM between host and sort CONTROL; watchdog under `SORT_WDOG_EN
module sort_mem_arbiter
  import sort_pkg::*;
#(
  parameter int unsigned AW        = SORT_AW,
  parameter int unsigned DW        = SORT_DW,
  parameter int unsigned TIMEOUT_W = 10
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          host_req,
  input  logic          host_we,
  input  logic [AW-1:0] host_addr,
  input  logic [DW-1:0] host_wdata,
  output logic          host_gnt,
  output logic [DW-1:0] host_rdata,
  output logic          host_rvalid,
  input  logic          sort_req,
  output logic          sort_start,
  input  logic          sort_done,
  input  logic          sort_rd,
  input  logic          sort_wr,
  input  logic [AW-1:0] sort_addr,
  input  logic [DW-1:0] sort_wdata,
  output logic [DW-1:0] sort_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          job_done,
  output logic          err
);

  state_t        state_q, state_d;
  logic          pend_q, pend_d;
  logic          rvalid_q, rvalid_d;
  logic          job_done_q, job_done_d;
  logic [DW-1:0] rdata_q, rdata_d;
  logic          wdog_expire;

`ifdef SORT_WDOG_EN
  logic err_q, err_d;

  sort_wdog_cnt #(.W(TIMEOUT_W)) u_wdog (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (state_q == ST_LAUNCH),
    .inc_i    (state_q == ST_RUN),
    .expire_o (wdog_expire)
  );

  assign err_d = err_q | ((state_q == ST_RUN) & ~sort_done & wdog_expire);

  always_ff @(posedge clk) begin
    if (rst) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign wdog_expire = 1'b0;
  assign err         = 1'b0;
`endif

  // A sort request always beats a host request in IDLE; the host is never preempted once granted.
  always_comb begin
    state_d    = state_q;
    pend_d     = pend_q;
    job_done_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (sort_req || pend_q) begin
          state_d = ST_LAUNCH;
        end else if (host_req) begin
          state_d = ST_HOST;
        end
      end
      ST_HOST: begin
        if (sort_req) begin
          pend_d = 1'b1;
        end
        if (!host_req) begin
          state_d = ST_IDLE;
        end
      end
      ST_LAUNCH: begin
        pend_d  = 1'b0;
        state_d = ST_RUN;
      end
      ST_RUN: begin
        if (sort_done) begin
          state_d    = ST_IDLE;
          job_done_d = 1'b1;
        end else if (wdog_expire) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (state_q)
      ST_HOST: begin
        if (host_req) begin
          mem_en    = 1'b1;
          mem_we    = host_we;
          mem_addr  = host_addr;
          mem_wdata = host_wdata;
        end
      end
      ST_RUN: begin
        mem_en    = sort_rd | sort_wr;
        mem_we    = sort_wr;
        mem_addr  = sort_addr;
        mem_wdata = sort_wdata;
      end
      default: ;
    endcase
  end

  // RAM data lands one cycle after the read; keep a copy so host_rdata holds after the valid cycle.
  assign rvalid_d = (state_q == ST_HOST) & host_req & ~host_we;
  assign rdata_d  = rvalid_q ? mem_rdata : rdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      pend_q     <= 1'b0;
      rvalid_q   <= 1'b0;
      job_done_q <= 1'b0;
      rdata_q    <= '0;
    end else begin
      state_q    <= state_d;
      pend_q     <= pend_d;
      rvalid_q   <= rvalid_d;
      job_done_q <= job_done_d;
      rdata_q    <= rdata_d;
    end
  end

  assign host_gnt    = (state_q == ST_HOST);
  assign host_rvalid = rvalid_q;
  assign host_rdata  = rdata_d;
  assign sort_start  = (state_q == ST_LAUNCH);
  assign busy        = (state_q == ST_LAUNCH) || (state_q == ST_RUN);
  assign job_done    = job_done_q;
  assign sort_rdata  = mem_rdata;

endmodule

// File: tb/tb_sort_mem_arbiter.sv
// tb/tb_sort_mem_arbiter.sv - scoreboard bench for sort_mem_arbiter with RAM, host and CONTROL models
module tb_sort_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic       host_req, host_we, host_gnt, host_rvalid;
  logic [3:0] host_addr;
  logic [7:0] host_wdata, host_rdata;
  logic       sort_req, sort_start, sort_done, sort_rd, sort_wr;
  logic [3:0] sort_addr;
  logic [7:0] sort_wdata, sort_rdata;
  logic       mem_en, mem_we;
  logic [3:0] mem_addr;
  logic [7:0] mem_wdata, mem_rdata;
  logic       busy, job_done, err;

  always #5 clk = ~clk;

  sort_mem_arbiter #(.AW(4), .DW(8), .TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .sort_req(sort_req), .sort_start(sort_start), .sort_done(sort_done),
    .sort_rd(sort_rd), .sort_wr(sort_wr), .sort_addr(sort_addr), .sort_wdata(sort_wdata),
    .sort_rdata(sort_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .busy(busy), .job_done(job_done), .err(err)
  );

  // Physical single-port RAM with one-cycle read latency.
  logic [7:0] ram [16];
  always @(posedge clk) begin
    if (mem_en) begin
      if (mem_we) ram[mem_addr] <= mem_wdata;
      else        mem_rdata <= ram[mem_addr];
    end
  end

  int checks = 0;
  int errors = 0;
  int cyc    = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference contents of the RAM as the host and CONTROL are entitled to expect them.
  logic [7:0] model [16];

  typedef struct {
    int         cyc;
    logic [7:0] d;
  } rd_exp_t;
  rd_exp_t exp_q[$];
  rd_exp_t mon_e;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (host_rvalid) begin
        if (exp_q.size() == 0) begin
          chk("host_rvalid_spurious", 32'(host_rvalid), 32'd0);
        end else begin
          mon_e = exp_q.pop_front();
          chk("host_rdata", 32'(host_rdata), 32'(mon_e.d));
          chk("host_rvalid_cycle", cyc, mon_e.cyc);
        end
      end else if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
        chk("host_rvalid_missing", 32'(host_rvalid), 32'd1);
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic chk_all_zero(input string name);
    chk(name, 32'({host_gnt, host_rvalid, sort_start, mem_en, mem_we, busy, job_done, err, host_rdata}), 32'd0);
  endtask

  task automatic host_open();
    host_req = 1'b1; host_we = 1'b0; host_addr = 4'd0; host_wdata = 8'd0;
    #1;
    chk("host_gnt_before_edge", 32'(host_gnt), 32'd0);
    step();
    chk("host_gnt_latency", 32'(host_gnt), 32'd1);
  endtask

  task automatic host_write(input logic [3:0] a, input logic [7:0] d);
    host_we = 1'b1; host_addr = a; host_wdata = d;
    #1;
    chk("host_write_mem", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'({2'b11, a, d}));
    step();
    model[a] = d;
  endtask

  task automatic host_read(input logic [3:0] a);
    rd_exp_t e;
    host_we = 1'b0; host_addr = a;
    step();
    e.cyc = cyc;
    e.d   = model[a];
    exp_q.push_back(e);
  endtask

  task automatic host_close();
    host_req = 1'b0; host_we = 1'b0;
    step();
  endtask

  task automatic launch();
    sort_req = 1'b1;
    step();
    sort_req = 1'b0;
    chk("launch_pulse", 32'({sort_start, busy, host_gnt}), 32'b110);
    step();
    chk("launch_to_run", 32'({sort_start, busy, host_gnt}), 32'b010);
  endtask

  // CONTROL stand-in: reads n words through the arbiter, sorts them, writes them back.
  task automatic control_sort(input int n);
    logic [7:0] loc[$];
    int         q[$];
    for (int i = 0; i < n; i++) begin
      sort_rd = 1'b1; sort_addr = 4'(i);
      step();
      loc.push_back(sort_rdata);
      chk("run_host_locked_out", 32'(host_gnt), 32'd0);
    end
    sort_rd = 1'b0;
    loc.sort();
    for (int i = 0; i < n; i++) begin
      sort_wr = 1'b1; sort_addr = 4'(i); sort_wdata = loc[i];
      step();
    end
    sort_wr = 1'b0;
    for (int i = 0; i < n; i++) q.push_back(int'(model[i]));
    q.sort();
    for (int i = 0; i < n; i++) model[i] = 8'(q[i]);
  endtask

  task automatic finish_job();
    sort_done = 1'b1;
    step();
    sort_done = 1'b0;
    chk("job_done_pulse", 32'({job_done, busy, sort_start, host_gnt}), 32'b1000);
    step();
    chk("job_done_clears", 32'(job_done), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout: bench did not reach its summary");
    $fatal(1);
  end

  initial begin
    int n;
    rst = 1'b1;
    host_req = 1'b0; host_we = 1'b0; host_addr = 4'd0; host_wdata = 8'd0;
    sort_req = 1'b0; sort_done = 1'b0; sort_rd = 1'b0; sort_wr = 1'b0;
    sort_addr = 4'd0; sort_wdata = 8'd0;
    step();
    step();
    chk_all_zero("reset_outputs");
    rst = 1'b0;

    host_open();
    host_write(4'd0, 8'h09);
    host_write(4'd1, 8'h03);
    host_write(4'd2, 8'h07);
    host_read(4'd1);
    host_close();

    host_req = 1'b1;
    launch();
    sort_rd = 1'b1; sort_wr = 1'b1; sort_addr = 4'd2; sort_wdata = 8'h0F;
    #1;
    chk("run_write_wins", 32'({mem_en, mem_we, mem_addr, mem_wdata}), 32'({2'b11, 4'd2, 8'h0F}));
    step();
    sort_rd = 1'b0; sort_wr = 1'b0;
    model[2] = 8'h0F;
    control_sort(3);
    finish_job();
    chk("host_after_job", 32'(host_gnt), 32'd1);
    for (int i = 0; i < 3; i++) host_read(4'(i));
    host_close();

    host_open();
    host_read(4'd0);
    sort_req = 1'b1;
    host_read(4'd1);
    sort_req = 1'b0;
    host_read(4'd2);
    chk("pend_no_preempt", 32'({sort_start, host_gnt}), 32'b01);
    host_close();
    chk("pend_wait_idle", 32'(sort_start), 32'd0);
    step();
    chk("pend_launch", 32'({sort_start, busy}), 32'b11);
    step();
    chk("pend_run", 32'({sort_start, busy}), 32'b01);
    for (int k = 0; k < 3; k++) begin
      step();
      chk("pend_run_no_restart", 32'(sort_start), 32'd0);
    end
    finish_job();
    for (int k = 0; k < 4; k++) begin
      step();
      chk("pend_single_launch", 32'({sort_start, busy}), 32'd0);
    end

    launch();
    for (int k = 0; k < 14; k++) begin
      step();
      chk("run_waiting", 32'({busy, err}), 32'b10);
    end
`ifdef SORT_WDOG_EN
    step();
    chk("wdog_abort", 32'({busy, err, job_done}), 32'b010);
    step();
    chk("wdog_err_sticky", 32'({err, job_done}), 32'b10);
`else
    for (int k = 0; k < 20; k++) begin
      step();
      chk("run_waits_forever", 32'({busy, err}), 32'b10);
    end
    finish_job();
`endif

    launch();
    sort_wr = 1'b1; sort_addr = 4'd5; sort_wdata = 8'hA5;
    step();
    model[5] = 8'hA5;
    sort_wr = 1'b0; sort_rd = 1'b1; sort_done = 1'b1; rst = 1'b1;
    step();
    chk_all_zero("reset_mid_run");
    rst = 1'b0; sort_done = 1'b0;
    step();
    chk("no_job_done_after_reset", 32'({job_done, busy, mem_en}), 32'd0);
    sort_rd = 1'b0;

    for (int j = 0; j < 4; j++) begin
      n = int'($urandom_range(16, 1));
      host_open();
      for (int i = 0; i < n; i++) host_write(4'(i), 8'($urandom_range(255, 0)));
      for (int k = 0; k < 3; k++) host_read(4'($urandom_range(n - 1, 0)));
      host_close();
      launch();
      control_sort(n);
      finish_job();
      host_open();
      for (int i = 0; i < n; i++) host_read(4'(i));
      host_close();
    end

    step();
    step();
    chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
